wb_ram_pattern_tester: RTL
==========================

// Module: wb_ram_pattern_tester
// PURPOSE
//  Parametrised Wishbone-classic master for board-level RAM bring-up; successor to the fixed switch/button harness.
//  Runs single write, single read, or a full fill-then-verify sweep. Counts mismatches, captures first failing
//  address, drives status LEDs and nibble display. Sits between board I/O and the SDRAM controller's WB slave port.
// PARAMETERS
//  ADDR_W   22  WB word-address width
//  DATA_W   16  WB data width; multiple of 8, 8..64
//  SWEEP_AW 10  sweep covers words 0..2**SWEEP_AW-1; must be <= ADDR_W
//  DIGITS   4   display nibbles driven on io_display
// PORTS
//  clock         in   1           system clock
//  reset         in   1           async, active-low; all state cleared while low
//  io_switches   in   18          [17:16] mode, [15:8] single-op address, [7:0] single-op data
//  io_start      in   1           async start request from button, active-high after board inversion
//  wb_adr_o      out  ADDR_W      WB address
//  wb_dat_o      out  DATA_W      WB write data
//  wb_dat_i      in   DATA_W      WB read data
//  wb_we_o       out  1           WB write enable
//  wb_sel_o      out  DATA_W/8    WB byte selects; always all-ones
//  wb_cyc_o      out  1           WB cycle
//  wb_stb_o      out  1           WB strobe
//  wb_ack_i      in   1           WB acknowledge
//  io_display    out  4*DIGITS    display value, nibble per digit
//  io_busy       out  1           operation in progress
//  io_pass       out  1           last sweep finished with zero errors
//  io_fail       out  1           last sweep finished with >=1 error
//  io_err_count  out  16          mismatch count, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset (async assert, sync deassert internally via 2-flop): every output 0, FSM IDLE, counters/capture regs 0.
//  io_start: 2-flop sync then rising-edge detect; FSM leaves IDLE 3 cycles after edge at io_start. Edge while busy ignored.
//  Mode latched at start: 00 single write, 01 single read, 10 address sweep, 11 LFSR sweep.
//  Single-op addr = zero-extended sw[15:8]; write data = sw[7:0] replicated across DATA_W.
//  WB transfer: cyc=stb=1 with adr/dat/we stable until cycle ack_i=1 sampled; next cycle cyc=stb=0 (>=1 idle cycle
//   between transfers). No timeout; a slave that never acks stalls the FSM until reset.
//  FSM: IDLE -> WR (mode 00) | RD (mode 01) | FILL (10/11).
//   WR: one write; on ack -> IDLE. RD: one read; on ack latch wb_dat_i -> display reg, -> IDLE.
//   FILL: write every addr 0..2**SWEEP_AW-1 ascending; after ack at last addr -> VERIFY (addr wraps to 0).
//   VERIFY: read every addr ascending, compare to expected; mismatch: err_count+1 (saturate), first mismatch
//    address captured once. After ack at last addr -> DONE.
//   DONE: one cycle; pass=(err_count==0), fail=!pass; -> IDLE. pass/fail held until next sweep start, then cleared.
//  Clearing: err_count and capture reg cleared on entry to FILL; single ops leave them untouched.
//  Address pattern: data = addr zero-extended/truncated to DATA_W.
//  io_busy = FSM != IDLE. io_display: single modes -> last read data (low 4*DIGITS bits, zero-extended);
//   sweep modes -> err_count while busy or fail=0, first-fail address when fail=1.
//  Reset mid-transfer: cyc/stb drop immediately with reset; slave must tolerate abandoned cycle.
// CONFIGURATION
//  RAM_TESTER_LFSR_EN defined: mode 11 data = 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, seed 16'hACE1,
//   one step per transfer, re-seeded on entry to FILL and VERIFY; replicated/truncated to DATA_W.
//  Not defined: no LFSR logic; mode 11 behaves exactly as mode 10.
// TESTING
//  1 sw=18'h0_12_5A start, 1-cycle-ack slave -> one write adr=0x12 dat=0x5A5A; then sw=18'h1_12_00 start
//    -> one read adr=0x12, display=0x5A5A, busy low after ack+1.
//  2 mode 10, ideal memory, ack delay 3 -> 1024 writes then 1024 reads in order, pass=1, fail=0, err_count=0.
//  3 mode 10, memory with data bit 3 stuck at 0 -> err_count=512, fail=1, display=0x0008 (first fail addr).
//  4 start pulses during sweep -> ignored; exactly 2048 transfers; err_count not cleared mid-run.
//  5 reset low mid-FILL at addr 0x100 -> all outputs 0 same cycle; after release no WB activity until new start.
//  6 mode 11: with RAM_TESTER_LFSR_EN first two words 0xACE1,0x5670, pass=1; without, data==addr as in test 2.

Source files
------------

// File: rtl/wb_ram_pattern_tester_if.sv
// Wishbone-classic bus bundle between the RAM pattern tester (master) and the
// memory controller's slave port.
interface wb_ram_pattern_tester_if #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0]   wb_adr_o;
   logic [DATA_W-1:0]   wb_dat_o;
   logic [DATA_W-1:0]   wb_dat_i;
   logic                wb_we_o;
   logic [DATA_W/8-1:0] wb_sel_o;
   logic                wb_cyc_o;
   logic                wb_stb_o;
   logic                wb_ack_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i
   );
endinterface

// File: rtl/wb_ram_pattern_tester.sv
// Wishbone-classic RAM bring-up master: single write/read or fill-then-verify sweep.
// Optional RAM_TESTER_LFSR_EN: mode 11 uses a 16-bit LFSR data pattern instead of address data.
module wb_ram_pattern_tester #(
   parameter int ADDR_W   = 22,
   parameter int DATA_W   = 16,
   parameter int SWEEP_AW = 10,
   parameter int DIGITS   = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [17:0]               io_switches,
   input  logic                      io_start,
   wb_ram_pattern_tester_if.master   wb,
   output logic [4*DIGITS-1:0]       io_display,
   output logic                      io_busy,
   output logic                      io_pass,
   output logic                      io_fail,
   output logic [15:0]               io_err_count
);
   localparam int DISP_W = 4*DIGITS;
   localparam int SEL_W  = DATA_W/8;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((64'd1 << SWEEP_AW) - 64'd1);

   typedef enum logic [2:0] {IDLE, WR, RD, FILL, VERIFY, DONE} state_t;

   // Reset asserts asynchronously but releases two clocks later, synchronised.
   logic [1:0] rst_sync;
   logic       rst_n_i;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_i = rst_sync[1];

   // Button synchroniser; the third stage only serves the rising-edge detect.
   logic [2:0] start_pipe;
   logic       start_edge;
   always_ff @(posedge clock or negedge rst_n_i) begin
      if (!rst_n_i) start_pipe <= '0;
      else          start_pipe <= {start_pipe[1:0], io_start};
   end
   assign start_edge = start_pipe[1] & ~start_pipe[2];

   state_t            state;
   logic [ADDR_W-1:0] adr_q, first_addr;
   logic [DATA_W-1:0] dat_q, rd_data, cur_pat;
   logic              we_q, cyc_q, stb_q;
   logic [SEL_W-1:0]  sel_q;
   logic              sweep_q, busy_q, pass_q, fail_q, captured_q;
   logic [15:0]       err_q;
   logic              last_addr, mismatch;

`ifdef RAM_TESTER_LFSR_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   logic [15:0] lfsr_q;
   logic        lfsr_mode_q;

   // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
   endfunction
`endif

   always_comb begin
      cur_pat = DATA_W'(adr_q);
`ifdef RAM_TESTER_LFSR_EN
      if (lfsr_mode_q) cur_pat = DATA_W'({4{lfsr_q}});
`endif
   end

   assign last_addr = (adr_q == LAST_ADDR);
   assign mismatch  = (wb.wb_dat_i != cur_pat);

   always_ff @(posedge clock or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         adr_q      <= '0;
         dat_q      <= '0;
         we_q       <= 1'b0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         sel_q      <= '0;
         rd_data    <= '0;
         sweep_q    <= 1'b0;
         busy_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         captured_q <= 1'b0;
         err_q      <= '0;
         first_addr <= '0;
`ifdef RAM_TESTER_LFSR_EN
         lfsr_q      <= '0;
         lfsr_mode_q <= 1'b0;
`endif
      end else begin
         sel_q <= '1;
         case (state)
            IDLE: if (start_edge) begin
               busy_q <= 1'b1;
               case (io_switches[17:16])
                  2'b00, 2'b01: begin
                     adr_q   <= ADDR_W'(io_switches[15:8]);
                     dat_q   <= DATA_W'({8{io_switches[7:0]}});
                     we_q    <= ~io_switches[16];
                     cyc_q   <= 1'b1;
                     stb_q   <= 1'b1;
                     sweep_q <= 1'b0;
                     state   <= io_switches[16] ? RD : WR;
                  end
                  default: begin
                     // Bus stays idle for the first cycle; FILL raises cyc itself.
                     adr_q      <= '0;
                     we_q       <= 1'b1;
                     sweep_q    <= 1'b1;
                     err_q      <= '0;
                     first_addr <= '0;
                     captured_q <= 1'b0;
                     pass_q     <= 1'b0;
                     fail_q     <= 1'b0;
                     state      <= FILL;
`ifdef RAM_TESTER_LFSR_EN
                     lfsr_q      <= LFSR_SEED;
                     lfsr_mode_q <= (io_switches[17:16] == 2'b11);
`endif
                  end
               endcase
            end
            WR, RD: if (wb.wb_ack_i) begin
               cyc_q  <= 1'b0;
               stb_q  <= 1'b0;
               we_q   <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
               if (state == RD) rd_data <= wb.wb_dat_i;
            end
            FILL, VERIFY: begin
               if (!cyc_q) begin
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
                  if (state == FILL) dat_q <= cur_pat;
               end else if (wb.wb_ack_i) begin
                  cyc_q <= 1'b0;
                  stb_q <= 1'b0;
                  adr_q <= last_addr ? '0 : adr_q + ADDR_W'(1);
`ifdef RAM_TESTER_LFSR_EN
                  lfsr_q <= last_addr ? LFSR_SEED : lfsr_next(lfsr_q);
`endif
                  if (state == VERIFY && mismatch) begin
                     if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                     if (!captured_q) begin
                        first_addr <= adr_q;
                        captured_q <= 1'b1;
                     end
                  end
                  if (last_addr) begin
                     we_q  <= 1'b0;
                     state <= (state == FILL) ? VERIFY : DONE;
                  end
               end
            end
            DONE: begin
               pass_q <= (err_q == 16'd0);
               fail_q <= (err_q != 16'd0);
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      if (!sweep_q)    io_display = DISP_W'(rd_data);
      else if (fail_q) io_display = DISP_W'(first_addr);
      else             io_display = DISP_W'(err_q);
   end

   assign wb.wb_adr_o  = adr_q;
   assign wb.wb_dat_o  = dat_q;
   assign wb.wb_we_o   = we_q;
   assign wb.wb_sel_o  = sel_q;
   assign wb.wb_cyc_o  = cyc_q;
   assign wb.wb_stb_o  = stb_q;
   assign io_busy      = busy_q;
   assign io_pass      = pass_q;
   assign io_fail      = fail_q;
   assign io_err_count = err_q;
endmodule
